// File: rtl/modport_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : modport_fifo
//  Purpose  : Single-clock synchronous FIFO. It is the storage block behind
//             the write-driver, write-monitor, read-driver and read-monitor
//             views of the FIFO interface.
//  Ports    : clk       - sole clock, rising edge
//             rst       - synchronous active-high reset
//             w_en      - write request
//             wdata     - write data
//             w_full    - FIFO holds DEPTH entries
//             r_en      - read request
//             rdata     - registered read data
//             r_empty   - FIFO holds no entries
//             count     - occupancy, 0..DEPTH
//             overflow  - sticky, write attempted while full
//             underflow - sticky, read attempted while empty
//  Options  : MODPORT_FIFO_ERR_EN - when defined, builds the sticky
//             overflow/underflow flags. Otherwise both outputs are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module modport_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  w_full,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  r_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] c_ptr_one = 1;

    // Storage is never reset. A reset only clears the pointers, which is
    // enough to discard everything that was held.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit above the index. That bit tells a
    // full FIFO apart from an empty one when the index bits match.
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic w_wr_accept;
    logic w_rd_accept;

    // Every flag is derived from registered pointers only, so no input
    // reaches an output combinationally.
    assign r_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                     (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
    assign count   = wptr_q - rptr_q;
    assign rdata   = rdata_q;

    // A request that is made against the wrong flag is simply ignored. That
    // covers a full FIFO that sees a write and a read together: only the
    // read goes through.
    assign w_wr_accept = w_en && !w_full;
    assign w_rd_accept = r_en && !r_empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        rdata_d = rdata_q;
        if (w_wr_accept) begin
            wptr_d = wptr_q + c_ptr_one;
        end
        if (w_rd_accept) begin
            rptr_d  = rptr_q + c_ptr_one;
            rdata_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_accept) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

`ifdef MODPORT_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Both flags watch the raw request against the flag, not the accepted
    // transfer. They then hold until the next reset.
    always_comb begin
        overflow_d  = overflow_q  | (w_en && w_full);
        underflow_d = underflow_q | (r_en && r_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_modport_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modport_fifo
//  Purpose  : Directed self-checking bench for modport_fifo
//             (DATA_WIDTH=8, DEPTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_modport_fifo;

    logic       clk;
    logic       rst;
    logic       w_en;
    logic [7:0] wdata;
    logic       w_full;
    logic       r_en;
    logic [7:0] rdata;
    logic       r_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_total;
    int n_pass;

`ifdef MODPORT_FIFO_ERR_EN
    localparam logic c_err_on = 1'b1;
`else
    localparam logic c_err_on = 1'b0;
`endif

    modport_fifo #(
        .DATA_WIDTH(8),
        .DEPTH     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w_en     (w_en),
        .wdata    (wdata),
        .w_full   (w_full),
        .r_en     (r_en),
        .rdata    (rdata),
        .r_empty  (r_empty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The run is bounded by a fixed number of edges. This watchdog exists
    // only to catch a stalled simulator.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1 time unit after the rising edge. Outputs are sampled
    // at the same point, so they reflect the edge that just happened.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        w_en    = 1'b1;
        r_en    = 1'b1;
        wdata   = 8'h77;

        // Reset held for two edges while both requests are active.
        tick();
        tick();
        rst  = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
        check("rst_empty", 16'(r_empty), 16'd1);
        check("rst_full", 16'(w_full), 16'd0);
        check("rst_count", 16'(count), 16'd0);
        check("rst_rdata", 16'(rdata), 16'h00);
        check("rst_ovf", 16'(overflow), 16'd0);
        check("rst_unf", 16'(underflow), 16'd0);

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            w_en  = 1'b1;
            wdata = 8'(i);
            tick();
            if (i == 0) begin
                check("first_wr_empty", 16'(r_empty), 16'd0);
                check("first_wr_count", 16'(count), 16'd1);
            end
            if (i == 14) begin
                check("almost_full", 16'(w_full), 16'd0);
            end
        end
        w_en = 1'b0;
        check("fill_full", 16'(w_full), 16'd1);
        check("fill_count", 16'(count), 16'd16);

        // Write while full: dropped, and the sticky overflow flag sets.
        w_en  = 1'b1;
        wdata = 8'hAA;
        tick();
        w_en = 1'b0;
        check("ovf_count", 16'(count), 16'd16);
        check("ovf_full", 16'(w_full), 16'd1);
        check("ovf_flag", 16'(overflow), 16'(c_err_on));
        check("ovf_unf", 16'(underflow), 16'd0);

        // Write and read together while full: only the read is accepted.
        w_en  = 1'b1;
        r_en  = 1'b1;
        wdata = 8'hBB;
        tick();
        w_en = 1'b0;
        r_en = 1'b0;
        check("full_wr_rd_count", 16'(count), 16'd15);
        check("full_wr_rd_rdata", 16'(rdata), 16'h00);

        // Drain the rest: 0x01..0x0F, with no 0xAA or 0xBB among them.
        for (int i = 1; i < 16; i++) begin
            r_en = 1'b1;
            tick();
            check($sformatf("drain_%0d", i), 16'(rdata), 16'(i));
        end
        r_en = 1'b0;
        check("drain_empty", 16'(r_empty), 16'd1);
        check("drain_count", 16'(count), 16'd0);

        // Read while empty: rdata holds, and the sticky underflow flag sets.
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("unf_rdata", 16'(rdata), 16'h0F);
        check("unf_count", 16'(count), 16'd0);
        check("unf_flag", 16'(underflow), 16'(c_err_on));

        // Write and read together while empty: only the write is accepted.
        w_en  = 1'b1;
        r_en  = 1'b1;
        wdata = 8'h20;
        tick();
        r_en = 1'b0;
        check("empty_wr_rd_count", 16'(count), 16'd1);
        check("empty_wr_rd_rdata", 16'(rdata), 16'h0F);
        for (int i = 1; i < 5; i++) begin
            wdata = 8'(8'h20 + i);
            tick();
        end
        w_en = 1'b0;
        check("five_count", 16'(count), 16'd5);

        // Twenty cycles of simultaneous traffic. The pointers wrap past
        // DEPTH, yet occupancy stays at 5 and the order is preserved.
        for (int k = 0; k < 20; k++) begin
            w_en  = 1'b1;
            r_en  = 1'b1;
            wdata = 8'(8'h25 + k);
            tick();
            check($sformatf("simul_count_%0d", k), 16'(count), 16'd5);
            check($sformatf("simul_rdata_%0d", k), 16'(rdata), 16'(8'h20 + k));
        end
        w_en = 1'b0;
        r_en = 1'b0;
        check("sticky_ovf", 16'(overflow), 16'(c_err_on));
        check("sticky_unf", 16'(underflow), 16'(c_err_on));

        // Reach 8 entries, then reset mid-operation.
        for (int i = 0; i < 3; i++) begin
            w_en  = 1'b1;
            wdata = 8'(8'h40 + i);
            tick();
        end
        w_en = 1'b0;
        check("mid_count8", 16'(count), 16'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", 16'(count), 16'd0);
        check("mid_rst_empty", 16'(r_empty), 16'd1);
        check("mid_rst_rdata", 16'(rdata), 16'h00);
        check("mid_rst_ovf", 16'(overflow), 16'd0);
        check("mid_rst_unf", 16'(underflow), 16'd0);

        w_en  = 1'b1;
        wdata = 8'h5C;
        tick();
        w_en = 1'b0;
        check("post_rst_count", 16'(count), 16'd1);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        check("post_rst_rdata", 16'(rdata), 16'h5C);
        check("post_rst_empty", 16'(r_empty), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
